// File: rtl/yacht_game_ctrl_pkg.sv
// Shared definitions for the yacht game controller: FSM encodings, section size,
// default parameter values and a small index helper.
package yacht_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ROLL      = 4'd1,
    ST_SETTLE    = 4'd2,
    ST_TURN      = 4'd3,
    ST_COMMIT    = 4'd4,
    ST_ADVANCE   = 4'd5,
    ST_GAME_OVER = 4'd6
  } state_e;

  localparam int UPPER_CATS = 6;
  // Upper subtotal never exceeds 6 * 255, so 11 bits cannot overflow.
  localparam int UPPER_W    = 11;

  localparam int DEF_NUM_PLAYERS  = 2;
  localparam int DEF_NUM_CATS     = 12;
  localparam int DEF_MAX_ROLLS    = 3;
  localparam int DEF_SCORE_W      = 9;
  localparam int DEF_BONUS_THRESH = 63;
  localparam int DEF_BONUS_VAL    = 35;

  function automatic int wrap_idx(input int v, input int n);
    if (v >= n) return v - n;
    if (v < 0)  return v + n;
    return v;
  endfunction

  function automatic logic is_upper(input logic [3:0] cat);
    return cat < 4'(UPPER_CATS);
  endfunction

endpackage

// File: rtl/yacht_game_ctrl_if.sv
// Player-button, dice and status bundle between the game controller and its environment.
interface yacht_game_ctrl_if import yacht_pkg::*; #(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int NUM_CATS    = DEF_NUM_CATS,
  parameter int SCORE_W     = DEF_SCORE_W
);
  logic                           btn_roll;
  logic                           btn_sel;
  logic                           btn_prev;
  logic                           btn_next;
  logic [7:0]                     calc_score;
  logic                           roll_trigger;
  logic [3:0]                     current_state;
  logic [2:0]                     player_turn;
  logic [3:0]                     category_idx;
  logic [3:0]                     round_num;
  logic [2:0]                     roll_count;
  logic [NUM_CATS-1:0]            used_mask;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic                           game_over;
  logic [2:0]                     winner;

  modport master (
    output btn_roll, btn_sel, btn_prev, btn_next, calc_score,
    input  roll_trigger, current_state, player_turn, category_idx, round_num,
           roll_count, used_mask, scores, game_over, winner
  );

  modport slave (
    input  btn_roll, btn_sel, btn_prev, btn_next, calc_score,
    output roll_trigger, current_state, player_turn, category_idx, round_num,
           roll_count, used_mask, scores, game_over, winner
  );
endinterface

// File: rtl/yacht_game_ctrl_cat_seek.sv
// Combinational search for the next, previous and lowest unused category,
// wrapping between NUM_CATS-1 and 0; the current index is kept when nothing else is free.
module yacht_cat_seek import yacht_pkg::*; #(
  parameter int NUM_CATS = DEF_NUM_CATS
) (
  input  logic [NUM_CATS-1:0] used_mask_i,
  input  logic [3:0]          cur_idx_i,
  output logic [3:0]          next_idx_o,
  output logic [3:0]          prev_idx_o,
  output logic [3:0]          lowest_idx_o
);
  localparam int CW = $clog2(NUM_CATS);

  logic next_found;
  logic prev_found;
  logic lowest_found;

  // NOTE: every output of an always_comb gets a default before any branch, so no path can infer a latch.
  always_comb begin
    next_idx_o = cur_idx_i;
    next_found = 1'b0;
    for (int k = 1; k < NUM_CATS; k++) begin
      if (!next_found && !used_mask_i[CW'(wrap_idx(int'(cur_idx_i) + k, NUM_CATS))]) begin
        next_idx_o = 4'(wrap_idx(int'(cur_idx_i) + k, NUM_CATS));
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    prev_idx_o = cur_idx_i;
    prev_found = 1'b0;
    for (int k = 1; k < NUM_CATS; k++) begin
      if (!prev_found && !used_mask_i[CW'(wrap_idx(int'(cur_idx_i) - k, NUM_CATS))]) begin
        prev_idx_o = 4'(wrap_idx(int'(cur_idx_i) - k, NUM_CATS));
        prev_found = 1'b1;
      end
    end
  end

  always_comb begin
    lowest_idx_o = '0;
    lowest_found = 1'b0;
    for (int c = 0; c < NUM_CATS; c++) begin
      if (!lowest_found && !used_mask_i[CW'(c)]) begin
        lowest_idx_o = 4'(c);
        lowest_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/yacht_game_ctrl.sv
// Yacht game controller: turn sequencing, category selection, per-player scoring
// with upper-section bonus and saturation, and end-of-game winner decision.
module yacht_game_ctrl import yacht_pkg::*; #(
  parameter int NUM_PLAYERS  = DEF_NUM_PLAYERS,
  parameter int NUM_CATS     = DEF_NUM_CATS,
  parameter int MAX_ROLLS    = DEF_MAX_ROLLS,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int BONUS_THRESH = DEF_BONUS_THRESH,
  parameter int BONUS_VAL    = DEF_BONUS_VAL
) (
  input logic              clk,
  input logic              reset_n,
  yacht_game_ctrl_if.slave bus
);
  localparam int          PW        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int          CW        = $clog2(NUM_CATS);
  localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;

  state_e     state_q, state_d;
  logic [2:0] player_q, player_d;
  logic [3:0] round_q, round_d;
  logic [2:0] rolls_q, rolls_d;
  logic [3:0] cat_q, cat_d;
  logic       commit_en;
  logic       clear_en;

  logic [SCORE_W-1:0]  score_q [NUM_PLAYERS];
  logic [UPPER_W-1:0]  upper_q [NUM_PLAYERS];
  logic                bonus_q [NUM_PLAYERS];
  logic [NUM_CATS-1:0] used_q  [NUM_PLAYERS];

  logic [PW-1:0]       pidx;
  logic                last_player;
  logic [2:0]          adv_player;
  logic [NUM_CATS-1:0] seek_mask;
  logic [3:0]          seek_next, seek_prev, seek_lowest;

  assign pidx        = PW'(player_q - 3'd1);
  assign last_player = (player_q == 3'(NUM_PLAYERS));
  assign adv_player  = last_player ? 3'd1 : player_q + 3'd1;
  // During ADVANCE the search looks ahead at the incoming player's mask.
  assign seek_mask   = (state_q == ST_ADVANCE) ? used_q[PW'(adv_player - 3'd1)] : used_q[pidx];

  yacht_cat_seek #(.NUM_CATS(NUM_CATS)) u_seek (
    .used_mask_i  (seek_mask),
    .cur_idx_i    (cat_q),
    .next_idx_o   (seek_next),
    .prev_idx_o   (seek_prev),
    .lowest_idx_o (seek_lowest)
  );

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    round_d   = round_q;
    rolls_d   = rolls_q;
    cat_d     = cat_q;
    commit_en = 1'b0;
    clear_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.btn_roll) state_d = ST_ROLL;
      ST_ROLL: begin
        rolls_d = rolls_q + 3'd1;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_TURN;
      ST_TURN: begin
        // One action per cycle: a higher-priority pulse swallows the rest.
        if (bus.btn_sel) begin
          state_d = ST_COMMIT;
        end else if (bus.btn_roll) begin
          if (rolls_q < 3'(MAX_ROLLS)) state_d = ST_ROLL;
        end else if (bus.btn_next) begin
          cat_d = seek_next;
        end else if (bus.btn_prev) begin
          cat_d = seek_prev;
        end
      end
      ST_COMMIT: begin
        commit_en = 1'b1;
        state_d   = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        rolls_d = '0;
        if (last_player && round_q == 4'(NUM_CATS)) begin
          state_d = ST_GAME_OVER;
        end else begin
          state_d  = ST_IDLE;
          player_d = adv_player;
          cat_d    = seek_lowest;
          if (last_player) round_d = round_q + 4'd1;
        end
      end
      ST_GAME_OVER: begin
        if (bus.btn_roll) begin
          clear_en = 1'b1;
          state_d  = ST_IDLE;
          player_d = 3'd1;
          round_d  = 4'd1;
          rolls_d  = '0;
          cat_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      player_q <= 3'd1;
      round_q  <= 4'd1;
      rolls_q  <= '0;
      cat_q    <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      round_q  <= round_d;
      rolls_q  <= rolls_d;
      cat_q    <= cat_d;
    end
  end

  logic               upper_hit;
  logic [UPPER_W-1:0] upper_new;
  logic               bonus_hit;
  logic [31:0]        sum;
  logic [SCORE_W-1:0] score_new;

  always_comb begin
    upper_hit = is_upper(cat_q);
    upper_new = upper_q[pidx] + (upper_hit ? UPPER_W'(bus.calc_score) : '0);
    bonus_hit = upper_hit && !bonus_q[pidx] && (upper_new >= UPPER_W'(BONUS_THRESH));
    sum       = 32'(score_q[pidx]) + 32'(bus.calc_score) + (bonus_hit ? 32'(BONUS_VAL) : 32'd0);
    score_new = (sum > SCORE_MAX) ? '1 : SCORE_W'(sum);
  end

  // NOTE: the per-player arrays are game state that must read zero after reset, so they are
  // explicitly reset here rather than left to power-up like a RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        score_q[p] <= '0;
        upper_q[p] <= '0;
        bonus_q[p] <= 1'b0;
        used_q[p]  <= '0;
      end
    end else if (clear_en) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        score_q[p] <= '0;
        upper_q[p] <= '0;
        bonus_q[p] <= 1'b0;
        used_q[p]  <= '0;
      end
    end else if (commit_en) begin
      score_q[pidx]            <= score_new;
      upper_q[pidx]            <= upper_new;
      bonus_q[pidx]            <= bonus_q[pidx] | bonus_hit;
      used_q[pidx][CW'(cat_q)] <= 1'b1;
    end
  end

  logic [SCORE_W-1:0] best;
  logic [2:0]         best_p;
  logic               tie;

  always_comb begin
    best   = '0;
    best_p = 3'd0;
    tie    = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (p == 0 || score_q[p] > best) begin
        best   = score_q[p];
        best_p = 3'(p + 1);
        tie    = 1'b0;
      end else if (score_q[p] == best) begin
        tie = 1'b1;
      end
    end
  end

  assign bus.roll_trigger  = (state_q == ST_ROLL);
  assign bus.current_state = state_q;
  assign bus.player_turn   = player_q;
  assign bus.category_idx  = cat_q;
  assign bus.round_num     = round_q;
  assign bus.roll_count    = rolls_q;
  assign bus.used_mask     = used_q[pidx];
  assign bus.game_over     = (state_q == ST_GAME_OVER);
  assign bus.winner        = (state_q == ST_GAME_OVER && !tie) ? best_p : 3'd0;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
    assign bus.scores[g*SCORE_W +: SCORE_W] = score_q[g];
  end

endmodule

// File: tb/tb_yacht_game_ctrl.sv
// Scoreboard bench for yacht_game_ctrl: a rule-level game model predicts roll pulses and
// commit results; a negedge monitor compares them as the controller presents them.
module tb_yacht_game_ctrl;
  import yacht_pkg::*;

  localparam int NP   = 2;
  localparam int NC   = 12;
  localparam int MR   = 3;
  localparam int SW   = 9;
  localparam int BT   = 63;
  localparam int BV   = 35;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  yacht_game_ctrl_if #(.NUM_PLAYERS(NP), .NUM_CATS(NC), .SCORE_W(SW)) bus ();

  yacht_game_ctrl #(
    .NUM_PLAYERS(NP), .NUM_CATS(NC), .MAX_ROLLS(MR), .SCORE_W(SW),
    .BONUS_THRESH(BT), .BONUS_VAL(BV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { int player; int round; int rolls; } roll_rec_t;
  typedef struct { int player; int cat; longint used; longint scores; } commit_rec_t;

  roll_rec_t   roll_q[$];
  commit_rec_t commit_q[$];

  int m_score [NP];
  int m_upper [NP];
  bit m_bonus [NP];
  bit m_used  [NP][NC];
  int m_player, m_round, m_rolls, m_cat;
  bit m_over;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      m_score[p] = 0;
      m_upper[p] = 0;
      m_bonus[p] = 0;
      for (int c = 0; c < NC; c++) m_used[p][c] = 0;
    end
    m_player = 1; m_round = 1; m_rolls = 0; m_cat = 0; m_over = 0;
  endfunction

  function automatic int seek(input int p, input int from, input int dir);
    for (int k = 1; k < NC; k++) begin
      int c;
      c = ((from + dir * k) % NC + NC) % NC;
      if (!m_used[p][c]) return c;
    end
    return from;
  endfunction

  function automatic int lowest(input int p);
    for (int c = 0; c < NC; c++) if (!m_used[p][c]) return c;
    return 0;
  endfunction

  function automatic longint used_word(input int p);
    longint w = 0;
    for (int c = 0; c < NC; c++) if (m_used[p][c]) w |= (64'd1 << c);
    return w;
  endfunction

  function automatic longint scores_word();
    longint w = 0;
    for (int p = 0; p < NP; p++) w |= (longint'(m_score[p]) << (p * SW));
    return w;
  endfunction

  function automatic int model_winner();
    int best = -1;
    int w = 0;
    for (int p = 0; p < NP; p++) begin
      if (m_score[p] > best) begin best = m_score[p]; w = p + 1; end
      else if (m_score[p] == best) w = 0;
    end
    return w;
  endfunction

  function automatic void model_commit(input int v);
    int p = m_player - 1;
    m_score[p] = (m_score[p] + v > SMAX) ? SMAX : m_score[p] + v;
    if (m_cat < 6) begin
      m_upper[p] += v;
      if (!m_bonus[p] && m_upper[p] >= BT) begin
        m_bonus[p] = 1;
        m_score[p] = (m_score[p] + BV > SMAX) ? SMAX : m_score[p] + BV;
      end
    end
    m_used[p][m_cat] = 1;
  endfunction

  function automatic void model_advance();
    m_rolls = 0;
    if (m_player == NP) begin
      if (m_round == NC) m_over = 1;
      else begin m_player = 1; m_round++; end
    end else begin
      m_player++;
    end
    if (!m_over) m_cat = lowest(m_player - 1);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input bit r, input bit s, input bit n, input bit p);
    bus.btn_roll = r; bus.btn_sel = s; bus.btn_next = n; bus.btn_prev = p;
    @(posedge clk); #1;
    bus.btn_roll = 0; bus.btn_sel = 0; bus.btn_next = 0; bus.btn_prev = 0;
  endtask

  task automatic do_roll();
    if (m_rolls < MR) begin
      roll_q.push_back('{m_player, m_round, m_rolls});
      m_rolls++;
      press(1, 0, 0, 0);
      idle(2);
    end else begin
      press(1, 0, 0, 0);
      idle(2);
      check("roll_count held at limit", bus.roll_count, MR);
      check("state after ignored roll", bus.current_state, ST_TURN);
    end
  endtask

  task automatic nav(input int dir);
    m_cat = seek(m_player - 1, m_cat, dir);
    press(0, 0, dir > 0, dir < 0);
    check("category_idx after nav", bus.category_idx, m_cat);
  endtask

  task automatic commit_turn(input int v, input bit with_next);
    commit_rec_t rec;
    bus.calc_score = 8'(v);
    model_commit(v);
    rec.player = m_player;
    rec.cat    = m_cat;
    rec.used   = used_word(m_player - 1);
    rec.scores = scores_word();
    commit_q.push_back(rec);
    press(0, 1, with_next, 0);
    check("state after sel", bus.current_state, ST_COMMIT);
    check("category held at commit", bus.category_idx, rec.cat);
    idle(2);
    model_advance();
    if (m_over) begin
      check("state at game end", bus.current_state, ST_GAME_OVER);
      check("game_over", bus.game_over, 1);
      check("winner", bus.winner, model_winner());
      check("round held at game end", bus.round_num, m_round);
      check("player held at game end", bus.player_turn, m_player);
    end else begin
      check("state after advance", bus.current_state, ST_IDLE);
      check("player_turn", bus.player_turn, m_player);
      check("round_num", bus.round_num, m_round);
      check("lowest unused category", bus.category_idx, m_cat);
      check("roll_count cleared", bus.roll_count, 0);
    end
  endtask

  task automatic random_turn(input int vmin, input int vmax);
    int extra = $urandom_range(0, MR);
    int navs  = $urandom_range(0, 3);
    do_roll();
    repeat (extra) do_roll();
    repeat (navs) nav(($urandom_range(0, 1) != 0) ? 1 : -1);
    commit_turn($urandom_range(vmin, vmax), 0);
  endtask

  task automatic clear_game();
    press(1, 0, 0, 0);
    model_reset();
    check("state after clear", bus.current_state, ST_IDLE);
    check("scores after clear", bus.scores, 0);
    check("round after clear", bus.round_num, 1);
    check("player after clear", bus.player_turn, 1);
    check("game_over after clear", bus.game_over, 0);
    check("used_mask after clear", bus.used_mask, 0);
  endtask

  roll_rec_t   mon_r;
  commit_rec_t mon_c;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.roll_trigger) begin
        if (roll_q.size() == 0) begin
          check("unexpected roll_trigger", 1, 0);
        end else begin
          mon_r = roll_q.pop_front();
          check("roll pulse player", bus.player_turn, mon_r.player);
          check("roll pulse round", bus.round_num, mon_r.round);
          check("roll pulse prior count", bus.roll_count, mon_r.rolls);
        end
      end
      if (bus.current_state == ST_ADVANCE) begin
        if (commit_q.size() == 0) begin
          check("unexpected commit", 1, 0);
        end else begin
          mon_c = commit_q.pop_front();
          check("commit player", bus.player_turn, mon_c.player);
          check("commit category", bus.category_idx, mon_c.cat);
          check("commit used_mask", bus.used_mask, mon_c.used);
          check("commit scores", bus.scores, mon_c.scores);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.btn_roll = 0; bus.btn_sel = 0; bus.btn_next = 0; bus.btn_prev = 0;
    bus.calc_score = 0;
    model_reset();
    idle(2);
    check("reset state", bus.current_state, ST_IDLE);
    check("reset player", bus.player_turn, 1);
    check("reset round", bus.round_num, 1);
    check("reset roll_count", bus.roll_count, 0);
    check("reset category", bus.category_idx, 0);
    check("reset scores", bus.scores, 0);
    check("reset used_mask", bus.used_mask, 0);
    check("reset game_over", bus.game_over, 0);
    check("reset winner", bus.winner, 0);
    check("reset roll_trigger", bus.roll_trigger, 0);
    reset_n = 1;
    idle(1);

    // Game 1: directed player-1 turns interleaved with random player-2 turns.
    press(0, 1, 1, 1);
    check("idle ignores sel/next/prev", bus.current_state, ST_IDLE);
    repeat (4) do_roll();
    check("roll_count after four presses", bus.roll_count, 3);
    commit_turn(20, 0);
    check("p1 score after 20", bus.scores[SW-1:0], 20);
    random_turn(0, 30);

    do_roll();
    commit_turn(25, 0);
    check("p1 score after 25", bus.scores[SW-1:0], 45);
    random_turn(0, 30);

    do_roll();
    check("p1 lowest unused is 2", bus.category_idx, 2);
    nav(-1);
    check("prev from 2 wraps to 11", bus.category_idx, 11);
    commit_turn(0, 0);
    random_turn(0, 30);

    do_roll();
    nav(-1);
    check("prev from 2 skips 11 to 10", bus.category_idx, 10);
    nav(1);
    check("next from 10 wraps to 2", bus.category_idx, 2);
    nav(-1);
    check("prev from 2 back to 10", bus.category_idx, 10);
    nav(1);
    commit_turn(18, 0);
    check("p1 score with bonus", bus.scores[SW-1:0], 98);
    random_turn(0, 30);

    do_roll();
    check("p1 category before sel+next", bus.category_idx, 3);
    commit_turn(5, 1);
    check("p1 score no second bonus", bus.scores[SW-1:0], 103);
    random_turn(0, 30);

    while (!m_over) random_turn(0, 30);
    clear_game();

    // Game 2: identical totals of 150 without bonus produce a tie.
    while (!m_over) begin
      do_roll();
      commit_turn((m_cat < 6) ? 10 : 15, 0);
    end
    check("tie game p1 total", bus.scores[SW-1:0], 150);
    check("tie game p2 total", bus.scores[2*SW-1:SW], 150);
    check("tie game winner", bus.winner, 0);
    clear_game();

    // Game 3: large values drive both totals into saturation.
    while (!m_over) random_turn(100, 255);
    check("p1 saturated", bus.scores[SW-1:0], SMAX);
    check("p2 saturated", bus.scores[2*SW-1:SW], SMAX);
    clear_game();

    // Reset landing in the COMMIT cycle discards the pending update.
    do_roll();
    bus.calc_score = 8'd77;
    press(0, 1, 0, 0);
    check("in COMMIT before reset", bus.current_state, ST_COMMIT);
    reset_n = 0;
    @(posedge clk); #1;
    check("state after commit reset", bus.current_state, ST_IDLE);
    check("scores after commit reset", bus.scores, 0);
    check("used_mask after commit reset", bus.used_mask, 0);
    check("roll_count after commit reset", bus.roll_count, 0);
    reset_n = 1;
    model_reset();
    idle(3);
    check("state stays idle after reset", bus.current_state, ST_IDLE);

    check("roll queue drained", roll_q.size(), 0);
    check("commit queue drained", commit_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/yacht_game_ctrl.md
YACHT_GAME_CTRL -- requirements
Module: yacht_game_ctrl

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players (legal 2..4).
REQ-002 Parameter NUM_CATS, default 12, score categories and rounds per game (legal 6..15).
REQ-003 Parameter MAX_ROLLS, default 3, rolls allowed per turn (legal 1..7).
REQ-004 Parameter SCORE_W, default 9, per-player total width.
REQ-005 Parameters BONUS_THRESH, default 63, and BONUS_VAL, default 35: upper-section bonus rule; categories 0..5 are the upper section.
REQ-006 One clock; reset is asynchronous and active-low: ports clk and reset_n.
REQ-007 clk  in  1  system clock.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 btn_roll, btn_sel, btn_prev, btn_next  in  1 each  single-cycle debounced pulses.
REQ-010 calc_score  in  8  score of current dice for category_idx, valid one cycle after roll_trigger.
REQ-011 roll_trigger  out  1  one-cycle pulse to the dice block.
REQ-012 current_state  out  4  FSM state code.
REQ-013 player_turn  out  3  active player, 1-based.
REQ-014 category_idx  out  4  selected category.
REQ-015 round_num  out  4  current round, 1..NUM_CATS.
REQ-016 roll_count  out  3  rolls taken this turn.
REQ-017 used_mask  out  NUM_CATS  used categories of active player.
REQ-018 scores  out  NUM_PLAYERS*SCORE_W  packed totals, player 1 in LSBs.
REQ-019 game_over  out  1  high in GAME_OVER; winner  out  3  1-based winner, 0 on tie.

Function
REQ-020 States: IDLE, ROLL, SETTLE, TURN, COMMIT, ADVANCE, GAME_OVER; encodings fixed in the package.
REQ-021 IDLE: btn_roll -> ROLL; all other buttons ignored.
REQ-022 ROLL: roll_trigger=1 for exactly one cycle, roll_count+1, -> SETTLE.
REQ-023 SETTLE: one cycle, no output change, -> TURN (calc_score is valid in TURN).
REQ-024 TURN: btn_roll with roll_count<MAX_ROLLS -> ROLL; btn_roll at roll_count==MAX_ROLLS ignored.
REQ-025 TURN: btn_next moves category_idx to the next unused category of the active player, btn_prev to the previous; both wrap between NUM_CATS-1 and 0; with one unused category left, the index is unchanged.
REQ-026 Simultaneous pulses in one cycle: priority sel > roll > next > prev; lower-priority pulses are dropped.
REQ-027 TURN: btn_sel -> COMMIT; category_idx is always unused when sel is accepted.
REQ-028 COMMIT, one cycle: score += calc_score; set used bit; upper subtotal += calc_score for category<6.
REQ-029 Bonus: BONUS_VAL is added once per player, in the COMMIT where the upper subtotal first reaches >= BONUS_THRESH.
REQ-030 Score addition saturates at 2^SCORE_W-1 and does not wrap.
REQ-031 ADVANCE: roll_count=0; player index wraps from NUM_PLAYERS to 1, and round_num+1 on wrap; category_idx = lowest unused category of the new player; -> IDLE.
REQ-032 ADVANCE when last player and round_num==NUM_CATS: -> GAME_OVER; round_num, player_turn held.
REQ-033 GAME_OVER: game_over=1; winner = player with strictly highest score, 0 on tie for highest; btn_roll clears all game state to reset values and goes to IDLE.
REQ-034 Inputs other than the listed transitions have no effect in any state.

Reset
REQ-035 reset_n low, asynchronous: state IDLE, player_turn 1, round_num 1, roll_count 0, category_idx 0, all scores, subtotals, bonus flags and used masks 0, roll_trigger 0, game_over 0, winner 0.
REQ-036 Reset mid-turn or mid-COMMIT discards the pending commit; no partial score update is retained.

Structure
REQ-037 Shared package yacht_pkg holds state encodings, the upper-section size (6) and default parameter values.
REQ-038 Sub-module yacht_cat_seek: combinational next/prev/lowest unused-category search over used_mask with wrap-around.
REQ-039 Per-player storage: score, upper subtotal, bonus flag and used mask arrays indexed by player.

Verification
REQ-040 Reset, btn_roll x4 in one turn -> exactly 3 roll_trigger pulses; roll_count stays 3.
REQ-041 Player 1 has used categories 0, 1 and 11, category_idx=10: btn_next -> 2; btn_prev from 2 -> 10.
REQ-042 Player 1 upper commits 20, 25, 18 -> scores 20, 45, 98 (bonus 35 once at the third commit); a further upper commit of 5 -> 103, with no second bonus.
REQ-043 btn_sel and btn_next pulsed in the same cycle in TURN -> COMMIT taken and category_idx unchanged at commit.
REQ-044 2 players play 12 rounds with totals 150/150 -> game_over=1 and winner=0; btn_roll -> IDLE with all scores 0.
REQ-045 reset_n asserted in the COMMIT cycle -> scores 0 and state IDLE on the next clock.
